uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter peripheral for the RISC-V `Computer`: the CPU's store path writes bytes into an 8-entry FIFO and the block serialises them onto a single `tx` line (8N1, LSB first). It is the outbound end of the console channel. In simulation, a bench-side UART receiver decodes `tx`, so program output becomes observable without probing internal memory. Status is readable combinationally so firmware can poll for full, empty and idle.

---
 rtl/uart_tx_mmio.sv | 102 ++++++++++
 tb/tb_uart_tx_mmio.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a push FIFO and pollable status
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [2:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_state;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic r_ovf, r_tx;
  logic [BW-1:0] r_cnt, w_cnt;
  logic [2:0] r_idx, w_idx;
  logic [7:0] r_shift, w_shift;
  logic w_full, w_empty, w_push, w_pop, w_bit_end, w_tx, w_txdata_wr;
  logic [31:0] w_count32;
  logic [3:0] w_count_sat;
  assign w_full      = r_count == FULL;
  assign w_empty     = r_count == '0;
  assign w_txdata_wr = write_enable && address == 3'd0;
  assign w_push      = w_txdata_wr && !w_full;
  assign w_bit_end   = r_cnt == LAST;
  assign tx          = r_tx;
  assign tx_busy     = r_state != IDLE || !w_empty;
  assign w_count32   = 32'(r_count);
  assign w_count_sat = w_count32 > 32'd15 ? 4'hF : w_count32[3:0];
  assign read_data   = address == 3'd1 ? {24'd0, w_count_sat, r_ovf, tx_busy, w_empty, w_full} : 32'd0;
  always_comb begin
    w_state = r_state;
    w_cnt   = w_bit_end ? '0 : r_cnt + 1'b1;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_pop   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_state = START;
          w_shift = r_mem[r_rptr];
        end
      end
      START: if (w_bit_end) begin
        w_state = DATA;
        w_idx   = '0;
      end
      DATA: if (w_bit_end) begin
        w_shift = r_shift >> 1;
        w_idx   = r_idx + 1'b1;
        w_state = r_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (w_bit_end) begin
        w_pop   = !w_empty;
        w_state = w_empty ? IDLE : START;
        w_shift = w_empty ? r_shift : r_mem[r_rptr];
      end
      default: w_state = IDLE;
    endcase
    // line level is registered from the next state so tx never glitches
    w_tx = w_state == START ? 1'b0 : w_state == DATA ? w_shift[0] : 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
      r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_ovf   <= (w_txdata_wr && w_full) || (r_ovf && !(write_enable && address == 3'd1 && write_data[3]));
    end
  end
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= write_data[7:0];
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: register-table checks, exact line-level checks and a serial receiver
// scoreboard that compares every decoded byte against the bytes queued on write.
module tb_uart_tx_mmio;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic reset, we, tx, busy;
  logic [2:0] addr;
  logic [31:0] wdata, rdata;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  bit rx_on = 1'b0, rx_ignore = 1'b0;
  logic [7:0] rx_b;
  logic rx_sok, rx_pok;
  typedef struct {
    logic        wr;
    logic [2:0]  waddr;
    logic [31:0] wd;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clock(clk), .reset(reset), .write_enable(we), .address(addr),
    .write_data(wdata), .read_data(rdata), .tx(tx), .tx_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  // Expects to be called just after the edge that starts the frame; returns just after
  // the edge following the last stop cycle, so consecutive calls check contiguity.
  task automatic line_check(input logic [7:0] b);
    logic [9:0] f;
    int bad;
    f = {1'b1, b, 1'b0};
    for (int s = 0; s < 10; s++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== f[s]) bad++;
        @(posedge clk); #1;
      end
      check($sformatf("line_%h_slot%0d", b, s), bad, 0);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_queue"}, 32'(exp_q.size()), 0);
    check({name, "_busy"}, busy, 0);
  endtask

  // Serial receiver: mid-bit sampling from the first low cycle of the start bit.
  always begin
    @(negedge clk);
    if (rx_on && tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      rx_sok = tx === 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        rx_b[k] = tx;
      end
      repeat (CPB) @(negedge clk);
      rx_pok = tx === 1'b1;
      if (!rx_ignore) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected actual=%h required=none", rx_b);
        end else
          check("rx_byte", {22'd0, rx_sok, rx_pok, rx_b}, {22'd0, 2'b11, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    vecs[0]  = '{1'b1, 3'd2, 32'h0000_00FF, 3'd1, 32'h2};
    vecs[1]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 3'd1, 32'h2};
    vecs[2]  = '{1'b1, 3'd7, 32'h0000_0012, 3'd1, 32'h2};
    vecs[3]  = '{1'b0, 3'd0, 32'h0,         3'd0, 32'h0};
    vecs[4]  = '{1'b0, 3'd0, 32'h0,         3'd1, 32'h2};
    vecs[5]  = '{1'b0, 3'd0, 32'h0,         3'd2, 32'h0};
    vecs[6]  = '{1'b0, 3'd0, 32'h0,         3'd3, 32'h0};
    vecs[7]  = '{1'b0, 3'd0, 32'h0,         3'd4, 32'h0};
    vecs[8]  = '{1'b0, 3'd0, 32'h0,         3'd5, 32'h0};
    vecs[9]  = '{1'b0, 3'd0, 32'h0,         3'd6, 32'h0};
    vecs[10] = '{1'b0, 3'd0, 32'h0,         3'd7, 32'h0};
    reset = 1'b1; we = 1'b0; addr = 3'd0; wdata = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    rx_on = 1'b1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    addr = 3'd1; #1;
    check("rst_status", rdata, 32'h2);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_20", bad, 0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wd);
      addr = vecs[i].raddr; #1;
      check($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end

    exp_q.push_back(8'h55);
    bus_write(3'd0, 32'h55);
    addr = 3'd1; #1;
    check("push_vis_status", rdata, 32'h14);
    check("start_lat_tx", tx, 1);
    @(posedge clk); #1;
    line_check(8'h55);
    check("busy_fall", busy, 0);

    exp_q.push_back(8'h41);
    exp_q.push_back(8'h0A);
    bus_write(3'd0, 32'h41);
    bus_write(3'd0, 32'h0A);
    line_check(8'h41);
    line_check(8'h0A);
    check("b2b_busy_fall", busy, 0);
    wait_drain("b2b");

    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(i));
      bus_write(3'd0, 32'(i));
    end
    addr = 3'd1; #1;
    check("ovf_status", rdata, 32'h8D);
    bus_write(3'd1, 32'h8);
    addr = 3'd1; #1;
    check("ovf_clear", rdata, 32'h85);
    wait_drain("ovf");
    addr = 3'd1; #1;
    check("ovf_drained_status", rdata, 32'h2);

    rx_ignore = 1'b1;
    bus_write(3'd0, 32'hFF);
    repeat (17) @(posedge clk);
    #1;
    check("midframe_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midframe_tx", tx, 1);
    addr = 3'd1; #1;
    check("midframe_status", rdata, 32'h2);
    bad = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("midframe_quiet", bad, 0);
    rx_ignore = 1'b0;

    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 5; j++) begin
        exp_q.push_back(8'(8'hA0 + b * 5 + j));
        bus_write(3'd0, 32'(8'hA0 + b * 5 + j));
      end
      wait_drain($sformatf("wrap%0d", b));
    end
    addr = 3'd1; #1;
    check("wrap_status", rdata, 32'h2);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
